// File: rtl/mux_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter_if
// Bus bundle between the requesters/consumer and the round-robin 8:1 mux.
//   req       : per-requester request lines (bit i = requester i)
//   data_in   : packed data words, requester i at [i*WIDTH +: WIDTH]
//   out_ready : consumer accepts out_data this cycle
//   out_valid : out_data/out_sel hold a granted transfer
//   out_data  : captured data word of the granted requester
//   out_sel   : index of the granted requester (mux select)
//   grant     : one-hot acknowledge on the completing cycle
//   xfer_cnt  : running count of completed transfers (wraps at 2^16)
// Modports: slave = arbiter side, master = requester/consumer side.
// ---------------------------------------------------------------------------
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [7:0]         req;
  logic [8*WIDTH-1:0] data_in;
  logic               out_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic [7:0]         grant;
  logic [15:0]        xfer_cnt;

  modport slave (
    input  req,
    input  data_in,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_sel,
    output grant,
    output xfer_cnt
  );

  modport master (
    output req,
    output data_in,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_sel,
    input  grant,
    input  xfer_cnt
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter in front of a shared 8:1 data mux. In IDLE the first
// requesting bit at or above the rotating pointer wins; its data word is
// captured and presented with out_valid until the consumer takes it. The
// transfer then completes, the pointer moves past the winner and the block
// spends one IDLE cycle before arbitrating again.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux_rr_arbiter_if.slave (req, data_in, out_ready in;
//           out_valid, out_data, out_sel, grant, xfer_cnt out)
// Parameters:
//   WIDTH    : data word width per requester (must match the interface)
//   CNT_INIT : value xfer_cnt takes in reset (normally zero; a nonzero
//              value lets the counter wrap be exercised quickly)
// ---------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int          WIDTH    = 8,
  parameter logic [15:0] CNT_INIT = 16'h0000
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_rr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [2:0]       ptr_r;
  logic [2:0]       ptr_s;
  logic             valid_r;
  logic             valid_s;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_s;
  logic [2:0]       sel_r;
  logic [2:0]       sel_s;
  logic [15:0]      cnt_r;
  logic [15:0]      cnt_s;

  logic [2:0]       pick_s;
  logic [WIDTH-1:0] pick_data_s;
  logic             handshake_s;
  logic [7:0]       grant_s;

  // First set request bit found searching upward from base, wrapping 7->0.
  // The loop runs from the farthest offset down to offset 0 so the nearest
  // requester is the last assignment and therefore wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] reqv,
                                         input logic [2:0] base);
    logic [2:0] idx;
    logic [2:0] pick;
    pick = base;
    for (int k = 7; k >= 0; k--) begin
      idx = base + 3'(k);
      if (reqv[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

  // One-hot decode of a 3-bit requester index.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

  // Arbitration winner and its data slice for the current request pattern.
  always_comb begin
    pick_s      = rr_pick(bus.req, ptr_r);
    pick_data_s = bus.data_in[32'(pick_s) * WIDTH +: WIDTH];
  end

  // A transfer completes only while a captured word is actually on offer;
  // out_ready alone never counts.
  always_comb begin
    handshake_s = valid_r & bus.out_ready;
    if (handshake_s) begin
      grant_s = onehot8(sel_r);
    end else begin
      grant_s = 8'h00;
    end
  end

  // Next-state and next-register computation for the IDLE/BUSY FSM.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    valid_s = valid_r;
    data_s  = data_r;
    sel_s   = sel_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.req != 8'h00) begin
          sel_s   = pick_s;
          data_s  = pick_data_s;
          valid_s = 1'b1;
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        // Captured word and select are frozen here regardless of req or
        // data_in, so a withdrawn request still delivers its data.
        if (handshake_s) begin
          ptr_s   = sel_r + 3'd1;
          valid_s = 1'b0;
          cnt_s   = cnt_r + 16'd1;
          state_s = IDLE;
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        valid_s = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any pending transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 3'd0;
      valid_r <= 1'b0;
      data_r  <= '0;
      sel_r   <= 3'd0;
      cnt_r   <= CNT_INIT;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      valid_r <= valid_s;
      data_r  <= data_s;
      sel_r   <= sel_s;
      cnt_r   <= cnt_s;
    end
  end

  assign bus.out_valid = valid_r;
  assign bus.out_data  = data_r;
  assign bus.out_sel   = sel_r;
  assign bus.xfer_cnt  = cnt_r;
  assign bus.grant     = grant_s;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_arbiter
// Directed bench for mux_rr_arbiter. Expected transfers (select, data,
// grant) are queued when the stimulus is set up and popped when a handshake
// is observed. A second instance with the counter starting at 16'hFFFF
// covers the wrap of xfer_cnt.
// ---------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] grant;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  mux_rr_arbiter_if #(.WIDTH(8)) m ();
  mux_rr_arbiter_if #(.WIDTH(8)) w ();

  mux_rr_arbiter #(.WIDTH(8), .CNT_INIT(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m)
  );

  mux_rr_arbiter #(.WIDTH(8), .CNT_INIT(16'hFFFF)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] sel, input logic [7:0] data,
                      input logic [7:0] grant);
    exp_t e;
    e.sel   = sel;
    e.data  = data;
    e.grant = grant;
    sb.push_back(e);
  endtask

  task automatic set_slice(input int i, input logic [7:0] v);
    m.data_in[i*8 +: 8] = v;
  endtask

  task automatic set_all(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      m.data_in[i*8 +: 8] = base + 8'(i);
    end
  endtask

  // Wait (bounded) for a handshake, compare it with the oldest expected
  // transfer, then step through the handshake edge.
  task automatic xfer(input string tag, input int budget);
    int   n;
    exp_t e;
    n = 0;
    #1;
    while (!(m.out_valid === 1'b1 && m.out_ready === 1'b1) && n < budget) begin
      step();
      n++;
    end
    checks++;
    assert (m.out_valid === 1'b1 && m.out_ready === 1'b1) else begin
      failures++;
      $error("FAIL %s_handshake observed valid=%b ready=%b expected valid=1 ready=1",
             tag, m.out_valid, m.out_ready);
    end
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL %s_scoreboard observed empty queue expected a pending entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_sel"},   32'(m.out_sel),  32'(e.sel));
      check({tag, "_data"},  32'(m.out_data), 32'(e.data));
      check({tag, "_grant"}, 32'(m.grant),    32'(e.grant));
    end
    step();
  endtask

  initial begin
    rst_n       = 1'b1;
    m.req       = 8'h00;
    m.data_in   = 64'h0;
    m.out_ready = 1'b0;
    w.req       = 8'h00;
    w.data_in   = 64'h0;
    w.out_ready = 1'b0;

    // Reset state, applied without any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(m.out_valid), 32'h0);
    check("rst_sel",   32'(m.out_sel),   32'h0);
    check("rst_data",  32'(m.out_data),  32'h0);
    check("rst_grant", 32'(m.grant),     32'h0);
    check("rst_cnt",   32'(m.xfer_cnt),  32'h0);
    check("rst_wrap_cnt", 32'(w.xfer_cnt), 32'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Idle with no requests: out_ready alone does nothing.
    m.out_ready = 1'b1;
    step();
    step();
    check("idle_valid", 32'(m.out_valid), 32'h0);
    check("idle_grant", 32'(m.grant),     32'h0);
    check("idle_cnt",   32'(m.xfer_cnt),  32'h0);

    // Single requester 2, one-cycle latency.
    set_slice(2, 8'd2);
    m.req = 8'h04;
    #1;
    check("single_pre_valid", 32'(m.out_valid), 32'h0);
    push(3'd2, 8'd2, 8'h04);
    step();
    check("single_lat_valid", 32'(m.out_valid), 32'h1);
    xfer("single", 1);
    m.req = 8'h00;
    #1;
    check("single_cnt",        32'(m.xfer_cnt),  32'h1);
    check("single_post_valid", 32'(m.out_valid), 32'h0);

    // Reset pulse between edges so contention starts from pointer 0.
    rst_n = 1'b0;
    #1;
    check("pulse_cnt", 32'(m.xfer_cnt), 32'h0);
    #1 rst_n = 1'b1;

    // Full contention: 16 transfers in strict rotation.
    set_all(8'h00);
    m.req       = 8'hFF;
    m.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(3'(i % 8), 8'(i % 8), 8'h01 << (i % 8));
    end
    for (int i = 0; i < 16; i++) begin
      xfer("contend", 4);
    end
    m.req = 8'h00;
    #1;
    check("contend_cnt", 32'(m.xfer_cnt), 32'd16);

    // Backpressure with requesters 0 and 7; data changes must not leak.
    set_all(8'hC0);
    m.out_ready = 1'b0;
    m.req       = 8'h81;
    step();
    set_slice(0, 8'h55);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(m.out_valid), 32'h1);
      check("bp_sel",   32'(m.out_sel),   32'h0);
      check("bp_data",  32'(m.out_data),  32'hC0);
      check("bp_grant", 32'(m.grant),     32'h0);
      step();
    end
    m.out_ready = 1'b1;
    push(3'd0, 8'hC0, 8'h01);
    xfer("bp_first", 1);
    push(3'd7, 8'hC7, 8'h80);
    xfer("bp_next", 4);
    m.req = 8'h00;
    #1;
    check("bp_cnt", 32'(m.xfer_cnt), 32'd18);

    // Withdrawal and data change while BUSY.
    m.out_ready = 1'b0;
    set_slice(4, 8'h34);
    m.req = 8'h10;
    step();
    check("wd_valid", 32'(m.out_valid), 32'h1);
    check("wd_sel",   32'(m.out_sel),   32'h4);
    m.req = 8'h00;
    set_slice(4, 8'hAA);
    step();
    step();
    check("wd_hold_data", 32'(m.out_data), 32'h34);
    m.out_ready = 1'b1;
    push(3'd4, 8'h34, 8'h10);
    xfer("wd", 1);
    check("wd_cnt", 32'(m.xfer_cnt), 32'd19);
    step();
    check("wd_idle_valid", 32'(m.out_valid), 32'h0);

    // Reset mid-transfer with requester 3 pending.
    m.out_ready = 1'b0;
    m.req       = 8'h08;
    step();
    check("mid_sel",   32'(m.out_sel),   32'h3);
    check("mid_valid", 32'(m.out_valid), 32'h1);
    #3;
    set_all(8'h20);
    m.req       = 8'hFF;
    m.out_ready = 1'b1;
    rst_n       = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m.out_valid), 32'h0);
    check("mid_rst_grant", 32'(m.grant),     32'h0);
    check("mid_rst_cnt",   32'(m.xfer_cnt),  32'h0);
    check("mid_rst_sel",   32'(m.out_sel),   32'h0);
    #1 rst_n = 1'b1;
    push(3'd0, 8'h20, 8'h01);
    xfer("post_rst", 4);
    m.req = 8'h00;
    #1;
    check("post_rst_cnt", 32'(m.xfer_cnt), 32'h1);

    // Counter wrap on the preloaded instance.
    w.data_in   = 64'h77;
    w.req       = 8'h01;
    w.out_ready = 1'b1;
    step();
    check("wrap_valid", 32'(w.out_valid), 32'h1);
    check("wrap_grant", 32'(w.grant),     32'h01);
    check("wrap_data",  32'(w.out_data),  32'h77);
    check("wrap_pre",   32'(w.xfer_cnt),  32'hFFFF);
    step();
    w.req = 8'h00;
    #1;
    check("wrap_cnt",   32'(w.xfer_cnt),  32'h0000);
    check("wrap_idle",  32'(w.out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
